pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the 9-bit ISA core and the next generation of the fetch stage. It adds several things the current fetch stage lacks: selectable program entry points, a pipeline stall, a halt/done handshake toward the testbench, signed relative branches, and an optional hardware return-address stack for call/return. It sits between the control decoder and the instruction ROM, and its `ProgCtr` output addresses the ROM directly.

## Interface
- `PC_W`, default 10: program-counter and `Target` width.
- `NUM_PROGS`, default 4: number of selectable programs. Entry addresses come from the package table `PROG_BASE`.
- `RAS_DEPTH`, default 4: return-address stack entries, ≥1. Used only when `PCSEQ_RAS_EN` is defined.
- `Clk` in 1: clock. All state changes on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `Start` in 1: arm/hold; the selected program launches when `Start` is released.
- `ProgSel` in `$clog2(NUM_PROGS)`: program index, sampled while `Start` is high.
- `Stall` in 1: hold PC; no stack change.
- `Jump` in 1: take branch to `Target`.
- `BranchAbsOrRel` in 1: 0 = absolute, 1 = relative (PC + signed `Target`).
- `Target` in `PC_W`: branch address or two's-complement offset.
- `Call` in 1: jump to `Target` (absolute) and push PC+1.
- `Ret` in 1: pop and jump to the popped address.
- `Halt` in 1: end of current program.
- `ProgCtr` out `PC_W`: registered program counter.
- `Done` out 1: high in state DONE.
- `StackErr` out 1: sticky overflow/underflow flag, cleared on a `Start` assertion.

## Operation
- States: RUN, ARMED, DONE. Reset state is RUN with `ProgCtr`=0, `Done`=0, `StackErr`=0, and the stack empty. Program 0 runs straight out of reset.
- Any state with `Start`=1:
  - Go to ARMED.
  - `ProgCtr` <= `PROG_BASE[ProgSel]` every cycle.
  - Stack cleared; `StackErr` cleared.
- ARMED with `Start`=0: go to RUN. `ProgCtr` holds the loaded base.
- RUN, actions in priority order (first match wins):
  1. `Stall`: hold.
  2. `Halt`: go to DONE, hold PC.
  3. `Ret`: PC <= top of stack, pop.
  4. `Call`: PC <= `Target`, push PC+1.
  5. `Jump`: PC <= `Target` if `BranchAbsOrRel`=0, else PC + `Target`.
  6. Otherwise: PC+1.
- DONE: PC holds and `Done`=1 until `Start` is asserted.
- `ProgSel` ≥ `NUM_PROGS`: base address 0.
- Arithmetic: all PC sums are modulo 2^`PC_W`. PC+1 from all-ones wraps to 0.
- Relative branch: `Target` is interpreted as signed `PC_W`.
- `Call` while the stack is full:
  - `StackErr` <= 1.
  - The push is dropped and the existing contents are kept.
  - The jump is still taken.
- `Ret` while the stack is empty: `StackErr` <= 1, and PC <= PC+1.
- A `Ret` with `Call` in the same cycle is treated as `Ret` only (priority), and `Call` is ignored.

## Timing
- `ProgCtr` is a register: the effect of any control input is visible one cycle after the sampling edge. There is no combinational path from inputs to `ProgCtr`.
- `Done` is registered and rises in the same cycle `ProgCtr` freezes after `Halt`.
- When `Start` falls, the first executed instruction address is `PROG_BASE[ProgSel]`, where `ProgSel` is the value sampled on the last `Start`-high edge.
- Reset assertion takes effect immediately, mid-operation included: PC=0, state RUN, stack emptied.

## Configuration
- `PCSEQ_RAS_EN` defined:
  - The return-address stack is instantiated; `Call` and `Ret` behave as above.
  - `StackErr` is live.
- `PCSEQ_RAS_EN` undefined:
  - No stack storage.
  - `Call` acts exactly as an absolute `Jump`.
  - `Ret` is ignored (PC+1).
  - `StackErr` is tied to 0.

## Structure
- Package `pc_seq_pkg` holds:
  - The state enum `pcseq_state_t` (RUN, ARMED, DONE).
  - The `PROG_BASE` constant array.
  - The default `PC_W`.
- Sub-module `ret_addr_stack`, parameters `DEPTH` and `W`:
  - Inputs: push, pop, clear, data in.
  - Outputs: top, full, empty.
  - Synchronous push/pop and asynchronous active-low reset.
  - Instantiated only under `PCSEQ_RAS_EN`.

## Test plan
- Reset released, no controls: `ProgCtr` counts 0,1,2,3. Hold `Stall` 2 cycles at PC=3: PC stays 3, then goes to 4.
- `Start`=1 with `ProgSel`=2 (`PROG_BASE[2]`=0x100) for 3 cycles, then release: PC=0x100 while held, then 0x101, 0x102.
- Relative branch from PC=0x010 with `Target`=0x3FE (-2): next PC=0x00E. From PC=0x3FF, no branch: PC wraps to 0x000.
- Call `Target`=0x050 at PC=0x020, run 3 cycles, then `Ret`: next PC=0x021. Then do `RAS_DEPTH`+1 nested calls: `StackErr`=1 and the last jump is still taken.
- `Halt` at PC=0x030: `Done`=1 and PC held for 10 cycles. Then `Start` with `ProgSel`=1: `Done`=0 and `StackErr` cleared.
- Reset pulsed mid-RUN at PC=0x123 between clock edges: `ProgCtr`=0 immediately. Rebuild without `PCSEQ_RAS_EN`: `Call` 0x050 gives PC=0x050, and the following `Ret` gives 0x051.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// +----------------------------------------------------------------------+
// | pc_seq_pkg: shared types and program entry table for pc_sequencer     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package pc_seq_pkg;

  localparam int PC_W_DEF = 10;
  localparam int PROG_N   = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } pcseq_state_t;

  localparam logic [PC_W_DEF-1:0] PROG_BASE [PROG_N] = '{
    10'h000, 10'h080, 10'h100, 10'h180
  };

  // Indices outside the configured program count or the table launch at 0.
  function automatic logic [PC_W_DEF-1:0] prog_base(input int unsigned idx,
                                                     input int unsigned nprogs);
    if (idx < nprogs && idx < PROG_N) return PROG_BASE[idx];
    return '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ret_addr_stack.sv
// +----------------------------------------------------------------------+
// | ret_addr_stack: LIFO of return addresses; overflowing pushes dropped  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module ret_addr_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [CNT_W-1:0] cnt_q;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign top_o   = empty_o ? '0 : mem_q[IDX_W'(cnt_q - CNT_W'(1))];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (push_i && !full_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o && !clear_i) begin
      mem_q[IDX_W'(cnt_q)] <= data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// +----------------------------------------------------------------------+
// | pc_sequencer: fetch PC sequencer with entry select, stall, halt and   |
// | call/return; return stack enabled by define PCSEQ_RAS_EN. Rev 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int NUM_PROGS = 4,
  parameter int RAS_DEPTH = 4,
  parameter int SEL_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [SEL_W-1:0] ProgSel,
  input  logic            Stall,
  input  logic            Jump,
  input  logic            BranchAbsOrRel,
  input  logic [PC_W-1:0] Target,
  input  logic            Call,
  input  logic            Ret,
  input  logic            Halt,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Done,
  output logic            StackErr
);

  pcseq_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            done_q;
  logic [PC_W-1:0] w_base;
  logic [PC_W-1:0] w_pc_inc;

  assign w_base   = PC_W'(prog_base(int'(ProgSel), NUM_PROGS));
  assign w_pc_inc = pc_q + PC_W'(1);

`ifdef PCSEQ_RAS_EN
  logic            w_push, w_pop, w_clear;
  logic [PC_W-1:0] w_top;
  logic            w_full, w_empty;
  logic            err_q, err_d;

  ret_addr_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk     (Clk),
    .rst_n   (Reset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .clear_i (w_clear),
    .data_i  (w_pc_inc),
    .top_o   (w_top),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign StackErr = err_q;
`else
  assign StackErr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PCSEQ_RAS_EN
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_clear = 1'b0;
    err_d   = err_q;
`endif
    if (Start) begin
      state_d = ARMED;
      pc_d    = w_base;
`ifdef PCSEQ_RAS_EN
      w_clear = 1'b1;
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        ARMED: state_d = RUN;
        RUN: begin
          if (Stall) begin
            pc_d = pc_q;
          end else if (Halt) begin
            state_d = DONE;
`ifdef PCSEQ_RAS_EN
          end else if (Ret) begin
            if (w_empty) begin
              err_d = 1'b1;
              pc_d  = w_pc_inc;
            end else begin
              pc_d  = w_top;
              w_pop = 1'b1;
            end
          end else if (Call) begin
            pc_d = Target;
            if (w_full) err_d  = 1'b1;
            else        w_push = 1'b1;
`else
          // Without a stack a return has nowhere to go; it simply advances.
          end else if (Ret) begin
            pc_d = w_pc_inc;
          end else if (Call) begin
            pc_d = Target;
`endif
          end else if (Jump) begin
            pc_d = BranchAbsOrRel ? (pc_q + Target) : Target;
          end else begin
            pc_d = w_pc_inc;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= (state_d == DONE);
    end
  end

`ifdef PCSEQ_RAS_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`endif

  assign ProgCtr = pc_q;
  assign Done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; expectations follow the
// PCSEQ_RAS_EN define the design is built with.
`default_nettype none

module tb_pc_sequencer;

`ifdef PCSEQ_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [1:0] ProgSel = 2'd0;
  logic       Stall = 1'b0;
  logic       Jump = 1'b0;
  logic       BranchAbsOrRel = 1'b0;
  logic [9:0] Target = 10'd0;
  logic       Call = 1'b0;
  logic       Ret = 1'b0;
  logic       Halt = 1'b0;
  wire  [9:0] ProgCtr;
  wire        Done;
  wire        StackErr;

  int checks   = 0;
  int failures = 0;

  pc_sequencer #(
    .PC_W      (10),
    .NUM_PROGS (4),
    .RAS_DEPTH (4)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Start          (Start),
    .ProgSel        (ProgSel),
    .Stall          (Stall),
    .Jump           (Jump),
    .BranchAbsOrRel (BranchAbsOrRel),
    .Target         (Target),
    .Call           (Call),
    .Ret            (Ret),
    .Halt           (Halt),
    .ProgCtr        (ProgCtr),
    .Done           (Done),
    .StackErr       (StackErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Start = 1'b0; Stall = 1'b0; Jump = 1'b0; BranchAbsOrRel = 1'b0;
    Call = 1'b0; Ret = 1'b0; Halt = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_pc", 32'(ProgCtr), 32'h0);
    chk("rst_done", 32'(Done), 32'h0);
    chk("rst_err", 32'(StackErr), 32'h0);
    tick();
    chk("rst_hold_pc", 32'(ProgCtr), 32'h0);
    Reset = 1'b1;

    tick(); chk("count1", 32'(ProgCtr), 32'h1);
    tick(); chk("count2", 32'(ProgCtr), 32'h2);
    tick(); chk("count3", 32'(ProgCtr), 32'h3);
    Stall = 1'b1;
    tick(); chk("stall1", 32'(ProgCtr), 32'h3);
    tick(); chk("stall2", 32'(ProgCtr), 32'h3);
    Stall = 1'b0;
    tick(); chk("after_stall", 32'(ProgCtr), 32'h4);

    Start = 1'b1; ProgSel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("armed_pc", 32'(ProgCtr), 32'h100);
    end
    Start = 1'b0;
    tick(); chk("launch_pc", 32'(ProgCtr), 32'h100);
    tick(); chk("launch_pc1", 32'(ProgCtr), 32'h101);
    tick(); chk("launch_pc2", 32'(ProgCtr), 32'h102);

    Jump = 1'b1; BranchAbsOrRel = 1'b0; Target = 10'h010;
    tick(); chk("abs_jump", 32'(ProgCtr), 32'h010);
    BranchAbsOrRel = 1'b1; Target = 10'h3FE;
    tick(); chk("rel_back2", 32'(ProgCtr), 32'h00E);
    BranchAbsOrRel = 1'b0; Target = 10'h3FF;
    tick(); chk("abs_top", 32'(ProgCtr), 32'h3FF);
    Jump = 1'b0;
    tick(); chk("wrap", 32'(ProgCtr), 32'h000);

    Jump = 1'b1; Target = 10'h020;
    tick(); chk("jump_020", 32'(ProgCtr), 32'h020);
    Jump = 1'b0; Call = 1'b1; Target = 10'h050;
    tick(); chk("call_050", 32'(ProgCtr), 32'h050);
    Call = 1'b0;
    tick(); tick(); tick();
    chk("in_sub", 32'(ProgCtr), 32'h053);
    Ret = 1'b1;
    tick(); chk("ret", 32'(ProgCtr), RAS ? 32'h021 : 32'h054);
    Ret = 1'b0;

    for (int i = 0; i < 5; i++) begin
      Call = 1'b1; Target = 10'(10'h060 + i);
      tick(); chk("nest_call", 32'(ProgCtr), 32'h060 + 32'(i));
      if (i == 3) chk("nest_not_full", 32'(StackErr), 32'h0);
    end
    chk("overflow_err", 32'(StackErr), RAS ? 32'h1 : 32'h0);
    Call = 1'b0; Ret = 1'b1;
    tick(); chk("ret_after_drop", 32'(ProgCtr), RAS ? 32'h063 : 32'h065);
    Ret = 1'b0;

    Jump = 1'b1; Target = 10'h030;
    tick(); chk("jump_030", 32'(ProgCtr), 32'h030);
    Jump = 1'b0; Halt = 1'b1;
    tick();
    chk("halt_pc", 32'(ProgCtr), 32'h030);
    chk("halt_done", 32'(Done), 32'h1);
    Halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("done_pc", 32'(ProgCtr), 32'h030);
      chk("done_flag", 32'(Done), 32'h1);
    end
    chk("err_sticky", 32'(StackErr), RAS ? 32'h1 : 32'h0);
    Start = 1'b1; ProgSel = 2'd1;
    tick();
    chk("restart_pc", 32'(ProgCtr), 32'h080);
    chk("restart_done", 32'(Done), 32'h0);
    chk("restart_err", 32'(StackErr), 32'h0);
    Start = 1'b0;
    tick(); chk("relaunch_pc", 32'(ProgCtr), 32'h080);

    Ret = 1'b1;
    tick();
    chk("underflow_pc", 32'(ProgCtr), 32'h081);
    chk("underflow_err", 32'(StackErr), RAS ? 32'h1 : 32'h0);
    Ret = 1'b0; Call = 1'b1; Target = 10'h070;
    tick(); chk("call_070", 32'(ProgCtr), 32'h070);
    Ret = 1'b1; Call = 1'b1; Target = 10'h0F0;
    tick(); chk("ret_over_call", 32'(ProgCtr), RAS ? 32'h082 : 32'h071);
    idle();

    Jump = 1'b1; Target = 10'h123;
    tick(); chk("jump_123", 32'(ProgCtr), 32'h123);
    Jump = 1'b0;
    #2 Reset = 1'b0;
    #1;
    chk("async_rst_pc", 32'(ProgCtr), 32'h0);
    chk("async_rst_done", 32'(Done), 32'h0);
    chk("async_rst_err", 32'(StackErr), 32'h0);
    #1 Reset = 1'b1;
    tick(); chk("post_rst_count", 32'(ProgCtr), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
